// File: rtl/div_req_sequencer.sv
// div_req_sequencer: FIFO-buffered REQ/ACK issue stage for the iterative divider, with a watchdog on hung operations
module div_req_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [15:0]            IN_A,
    input  logic [15:0]            IN_D,
    output logic                   DIV_REQ,
    output logic [15:0]            DIV_A,
    output logic [15:0]            DIV_D,
    input  logic                   DIV_ACK,
    input  logic                   DIV_FDBZ,
    input  logic [15:0]            DIV_Q,
    input  logic [15:0]            DIV_R,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [15:0]            OUT_Q,
    output logic [15:0]            OUT_R,
    output logic                   OUT_DBZ,
    output logic                   OUT_TO,
    output logic [$clog2(DEPTH):0] COUNT,
    output logic                   BUSY
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;
    state_t        state;
    logic [15:0]   mem_a [DEPTH];
    logic [15:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [WW-1:0] wd;
    logic          push, pop, slot_free, ack_cap, to_cap;
    // DEPTH is a power of two, so COUNT < DEPTH is just the top bit being clear
    assign IN_READY  = !COUNT[AW];
    assign push      = IN_VALID && IN_READY;
    assign pop       = state == IDLE && COUNT != '0;
    assign slot_free = !OUT_VALID || OUT_READY;
    assign ack_cap   = state == ISSUE && DIV_ACK && slot_free;
    assign to_cap    = state == ISSUE && !DIV_ACK && wd == WW'(TIMEOUT) && slot_free;
    assign BUSY      = state != IDLE || COUNT != '0;
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_a[wr_ptr] <= IN_A;
            mem_d[wr_ptr] <= IN_D;
        end
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            COUNT     <= '0;
            wd        <= '0;
            DIV_REQ   <= 1'b0;
            DIV_A     <= '0;
            DIV_D     <= '0;
            OUT_VALID <= 1'b0;
            OUT_Q     <= '0;
            OUT_R     <= '0;
            OUT_DBZ   <= 1'b0;
            OUT_TO    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            COUNT <= COUNT + (AW+1)'(push) - (AW+1)'(pop);
            if (OUT_READY) OUT_VALID <= 1'b0;
            case (state)
                IDLE: if (pop) begin
                    DIV_A   <= mem_a[rd_ptr];
                    DIV_D   <= mem_d[rd_ptr];
                    DIV_REQ <= 1'b1;
                    wd      <= '0;
                    state   <= ISSUE;
                end
                ISSUE: if (ack_cap || to_cap) begin
                    OUT_Q     <= ack_cap ? DIV_Q : '0;
                    OUT_R     <= ack_cap ? DIV_R : '0;
                    OUT_DBZ   <= ack_cap && DIV_FDBZ;
                    OUT_TO    <= to_cap;
                    OUT_VALID <= 1'b1;
                    DIV_REQ   <= 1'b0;
                    state     <= RELEASE;
                end else if (!DIV_ACK && wd != WW'(TIMEOUT)) begin
                    wd <= wd + WW'(1);
                end
                RELEASE: if (!DIV_ACK) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
